// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the main pipeline (A) and the
// multicycle unit (B): A has fixed priority, with a starvation guard for B.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              we3,
    output logic [ADDR_W-1:0] addr_w3,
    output logic [DATA_W-1:0] write_data3,
    output logic              collision
);

    typedef enum logic {
        NORMAL,
        FORCE_B
    } state_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT - 1);

    state_t            state;
    state_t            state_next;
    logic [3:0]        wait_cnt;
    logic [3:0]        wait_next;
    logic              a_xfer;
    logic              b_xfer;
    logic              b_stalled;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Grants depend only on valids and state, never on addr/data.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst) begin
            case (state)
                NORMAL: begin
                    a_ready = a_valid;
                    b_ready = b_valid && !a_valid;
                end
                FORCE_B: begin
                    b_ready = b_valid;
                    a_ready = a_valid && !b_valid;
                end
                default: begin
                    a_ready = 1'b0;
                    b_ready = 1'b0;
                end
            endcase
        end
    end

    assign a_xfer    = a_valid && a_ready;
    assign b_xfer    = b_valid && b_ready;
    assign b_stalled = b_valid && !b_ready;
    assign sel_addr  = a_xfer ? a_addr : b_addr;
    assign sel_data  = a_xfer ? a_data : b_data;

    always_comb begin
        state_next = state;
        wait_next  = '0;
        if (b_stalled) begin
            wait_next = wait_cnt + 4'd1;
        end
        case (state)
            NORMAL: begin
                if (b_stalled && wait_cnt == WAIT_LIMIT) begin
                    state_next = FORCE_B;
                end
            end
            FORCE_B: begin
                if (b_xfer || !b_valid) begin
                    state_next = NORMAL;
                end
            end
            default: state_next = NORMAL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= NORMAL;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    // Register-0 writes are consumed by the handshake but never issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we3         <= 1'b0;
            addr_w3     <= '0;
            write_data3 <= '0;
            collision   <= 1'b0;
        end else begin
            we3       <= 1'b0;
            collision <= a_valid && b_valid;
            if ((a_xfer || b_xfer) && sel_addr != '0) begin
                we3         <= 1'b1;
                addr_w3     <= sel_addr;
                write_data3 <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ready;
    logic        we3;
    logic [4:0]  addr_w3;
    logic [31:0] write_data3;
    logic        collision;

    int unsigned total = 0;
    int unsigned bad   = 0;

    regfile_wb_arbiter #(
        .DATA_W  (32),
        .ADDR_W  (5),
        .MAX_WAIT(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (a_valid),
        .a_addr     (a_addr),
        .a_data     (a_data),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .b_ready    (b_ready),
        .we3        (we3),
        .addr_w3    (addr_w3),
        .write_data3(write_data3),
        .collision  (collision)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    // Contention table: A addresses 1..5 against B (addr 9) with MAX_WAIT=4.
    logic       con_ar  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [4:0] con_adr [6] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd9, 5'd5};
    logic       con_col [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    // Starvation restart: B drops for one cycle, then needs 4 more stalls.
    logic       st_bv   [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       st_br   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst     = 1'b1;
        a_valid = 1'b1;
        a_addr  = 5'd0;
        a_data  = '0;
        b_valid = 1'b1;
        b_addr  = 5'd0;
        b_data  = '0;
        edge_step();
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        chk("rst_we3", 32'(we3), 32'd0);
        chk("rst_addr", 32'(addr_w3), 32'd0);
        chk("rst_data", write_data3, 32'd0);
        chk("rst_col", 32'(collision), 32'd0);
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst     = 1'b0;

        // A only
        a_valid = 1'b1;
        a_addr  = 5'd5;
        a_data  = 32'hDEADBEEF;
        #1;
        chk("aonly_a_ready", 32'(a_ready), 32'd1);
        chk("aonly_b_ready", 32'(b_ready), 32'd0);
        edge_step();
        a_valid = 1'b0;
        chk("aonly_we3", 32'(we3), 32'd1);
        chk("aonly_addr", 32'(addr_w3), 32'd5);
        chk("aonly_data", write_data3, 32'hDEADBEEF);
        chk("aonly_col", 32'(collision), 32'd0);
        edge_step();
        chk("aonly_we3_off", 32'(we3), 32'd0);
        chk("aonly_hold", 32'(addr_w3), 32'd5);

        // Contention
        a_valid = 1'b1;
        a_addr  = 5'd1;
        a_data  = 32'h11;
        b_valid = 1'b1;
        b_addr  = 5'd9;
        b_data  = 32'h99;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("con%0d_a_ready", i), 32'(a_ready), 32'(con_ar[i]));
            chk($sformatf("con%0d_b_ready", i), 32'(b_ready), 32'(!con_ar[i]));
            edge_step();
            chk($sformatf("con%0d_we3", i), 32'(we3), 32'd1);
            chk($sformatf("con%0d_addr", i), 32'(addr_w3), 32'(con_adr[i]));
            chk($sformatf("con%0d_data", i), write_data3, (con_adr[i] == 5'd9) ? 32'h99 : 32'(con_adr[i]) * 32'h11);
            chk($sformatf("con%0d_col", i), 32'(collision), 32'(con_col[i]));
            if (con_ar[i]) begin
                a_addr = a_addr + 5'd1;
                a_data = 32'(a_addr) * 32'h11;
            end else begin
                b_valid = 1'b0;
            end
        end
        a_valid = 1'b0;
        edge_step();
        chk("con_end_we3", 32'(we3), 32'd0);
        chk("con_end_col", 32'(collision), 32'd0);

        // Zero address from B: consumed, not issued
        b_valid = 1'b1;
        b_addr  = 5'd0;
        b_data  = 32'h1234;
        #1;
        chk("zero_b_ready", 32'(b_ready), 32'd1);
        edge_step();
        b_valid = 1'b0;
        chk("zero_we3", 32'(we3), 32'd0);
        chk("zero_addr_hold", 32'(addr_w3), 32'd5);
        chk("zero_data_hold", write_data3, 32'h55);

        // Starvation counter restart
        a_valid = 1'b1;
        a_addr  = 5'd3;
        a_data  = 32'h33;
        b_addr  = 5'd10;
        b_data  = 32'hAA;
        for (int i = 0; i < 9; i++) begin
            b_valid = st_bv[i];
            #1;
            chk($sformatf("st%0d_b_ready", i), 32'(b_ready), 32'(st_br[i]));
            chk($sformatf("st%0d_a_ready", i), 32'(a_ready), 32'(!st_br[i]));
            edge_step();
            chk($sformatf("st%0d_addr", i), 32'(addr_w3), st_br[i] ? 32'd10 : 32'd3);
            chk($sformatf("st%0d_col", i), 32'(collision), 32'(st_bv[i]));
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        edge_step();

        // Async reset between transfer and issue
        a_valid = 1'b1;
        a_addr  = 5'd7;
        a_data  = 32'h77;
        #1;
        chk("arst_a_ready", 32'(a_ready), 32'd1);
        edge_step();
        chk("arst_pending_we3", 32'(we3), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_we3", 32'(we3), 32'd0);
        chk("arst_addr", 32'(addr_w3), 32'd0);
        chk("arst_data", write_data3, 32'd0);
        chk("arst_a_ready_in_rst", 32'(a_ready), 32'd0);
        a_valid = 1'b0;
        #1;
        rst = 1'b0;
        edge_step();
        chk("arst_after_we3", 32'(we3), 32'd0);
        chk("arst_after_addr", 32'(addr_w3), 32'd0);
        // State must be NORMAL again: A wins immediately over B.
        a_valid = 1'b1;
        a_addr  = 5'd2;
        b_valid = 1'b1;
        #1;
        chk("arst_normal_a", 32'(a_ready), 32'd1);
        chk("arst_normal_b", 32'(b_ready), 32'd0);
        a_valid = 1'b0;
        b_valid = 1'b0;
        edge_step();

        // Back-to-back A writes, 1..8
        a_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            a_addr = 5'(i);
            a_data = 32'h100 + 32'(i);
            edge_step();
            chk($sformatf("b2b%0d_we3", i), 32'(we3), 32'd1);
            chk($sformatf("b2b%0d_addr", i), 32'(addr_w3), 32'(i));
            chk($sformatf("b2b%0d_data", i), write_data3, 32'h100 + 32'(i));
        end
        a_valid = 1'b0;
        edge_step();
        chk("b2b_end_we3", 32'(we3), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
